// File: rtl/cnt4b_ctrl_panel.sv
// Front-panel controller for the 4-bit up/down MIN/MAX counter: debounced run/stop,
// up/down and limit-load buttons, limit validation, count-enable prescaler and reload request.
module cnt4b_ctrl_panel #(
  parameter int W        = 4,
  parameter int DB_CYC   = 4,
  parameter int TICK_DIV = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         BTN_SS,
  input  logic         BTN_MODE,
  input  logic         BTN_LOAD,
  input  logic [W-1:0] SW,
  output logic         RUN,
  output logic         SS,
  output logic         MODE,
  output logic [W-1:0] MIN,
  output logic [W-1:0] MAX,
  output logic         CNT_RST,
  output logic         LOADING,
  output logic         ERR
);

  localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYC - 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam int B_SS   = 0;
  localparam int B_MODE = 1;
  localparam int B_LOAD = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GET_MIN = 2'd1,
    ST_GET_MAX = 2'd2,
    ST_CHECK   = 2'd3
  } state_e;

  logic [2:0]         btn_raw_s;
  logic [2:0]         sync1_q, sync2_q, level_q, level_d, press_s;
  logic [2:0][CW-1:0] db_cnt_q, db_cnt_d;

  state_e         state_q, state_d;
  logic           run_q, run_d, mode_q, mode_d, err_q, err_d;
  logic           loading_q, loading_d, cnt_rst_q, cnt_rst_d, ss_q, ss_d;
  logic           init_q, run_eff_s;
  logic [W-1:0]   min_q, min_d, max_q, max_d;
  logic [W-1:0]   stage_min_q, stage_min_d, stage_max_q, stage_max_d;
  logic [PW-1:0]  presc_q, presc_d;

  assign btn_raw_s = {BTN_LOAD, BTN_MODE, BTN_SS};

  // Stable-counter debounce; the press fires on the same edge the new level is accepted.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    press_s  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = sync2_q[i];
          press_s[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CW'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  // Button synchronisers and debounce state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 3'b000;
      sync2_q  <= 3'b000;
      level_q  <= 3'b000;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= btn_raw_s;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Limit-entry FSM, button commands, prescaler and registered output values.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    mode_d      = mode_q;
    err_d       = err_q;
    min_d       = min_q;
    max_d       = max_q;
    stage_min_d = stage_min_q;
    stage_max_d = stage_max_q;
    cnt_rst_d   = init_q;
    case (state_q)
      ST_IDLE: begin
        if (press_s[B_LOAD]) begin
          state_d = ST_GET_MIN;
        end else if (press_s[B_MODE]) begin
          mode_d    = ~mode_q;
          cnt_rst_d = 1'b1;
        end else if (press_s[B_SS]) begin
          run_d = ~run_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_MIN: begin
        if (press_s[B_LOAD]) begin
          stage_min_d = SW;
          state_d     = ST_GET_MAX;
        end else begin
          state_d = ST_GET_MIN;
        end
      end
      ST_GET_MAX: begin
        if (press_s[B_LOAD]) begin
          stage_max_d = SW;
          state_d     = ST_CHECK;
        end else begin
          state_d = ST_GET_MAX;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (stage_min_q <= stage_max_q) begin
          min_d     = stage_min_q;
          max_d     = stage_max_q;
          err_d     = 1'b0;
          cnt_rst_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    loading_d = (state_d != ST_IDLE);
    run_eff_s = run_q & ~loading_q;
    if (run_eff_s) begin
      presc_d = (presc_q == TICK_LAST) ? '0 : presc_q + PW'(1);
    end else begin
      presc_d = '0;
    end
    // Tick only if still running after this edge; a reload cycle never counts.
    ss_d = run_eff_s & run_d & ~loading_d & (presc_q == TICK_LAST) & ~cnt_rst_d;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      run_q       <= 1'b0;
      mode_q      <= 1'b1;
      err_q       <= 1'b0;
      min_q       <= '0;
      max_q       <= '1;
      stage_min_q <= '0;
      stage_max_q <= '0;
      loading_q   <= 1'b0;
      cnt_rst_q   <= 1'b1;
      init_q      <= 1'b1;
      ss_q        <= 1'b0;
      presc_q     <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      min_q       <= min_d;
      max_q       <= max_d;
      stage_min_q <= stage_min_d;
      stage_max_q <= stage_max_d;
      loading_q   <= loading_d;
      cnt_rst_q   <= cnt_rst_d;
      init_q      <= 1'b0;
      ss_q        <= ss_d;
      presc_q     <= presc_d;
    end
  end

  assign RUN     = run_q;
  assign SS      = ss_q;
  assign MODE    = mode_q;
  assign MIN     = min_q;
  assign MAX     = max_q;
  assign CNT_RST = cnt_rst_q;
  assign LOADING = loading_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_cnt4b_ctrl_panel.sv
// Bench for cnt4b_ctrl_panel: directed and random button traffic, a behavioural model pushes
// the expected output set per clock edge and a separate monitor pops and compares it.
module tb_cnt4b_ctrl_panel;
  localparam int W  = 4;
  localparam int DB = 4;
  localparam int TD = 10;
  localparam int PH_IDLE = 0;
  localparam int PH_MIN  = 1;
  localparam int PH_MAX  = 2;
  localparam int PH_CHK  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic b_ss = 1'b0, b_mode = 1'b0, b_load = 1'b0;
  logic [W-1:0] sw = '0;
  logic RUN, SS, MODE, CNT_RST, LOADING, ERR;
  logic [W-1:0] MIN, MAX;

  always #5 clk = ~clk;

  cnt4b_ctrl_panel #(.W(W), .DB_CYC(DB), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .BTN_SS(b_ss), .BTN_MODE(b_mode), .BTN_LOAD(b_load), .SW(sw),
    .RUN(RUN), .SS(SS), .MODE(MODE), .MIN(MIN), .MAX(MAX),
    .CNT_RST(CNT_RST), .LOADING(LOADING), .ERR(ERR)
  );

  typedef struct packed {
    logic         run;
    logic         ss;
    logic         mode;
    logic [W-1:0] mn;
    logic [W-1:0] mx;
    logic         cnt_rst;
    logic         loading;
    logic         err;
  } obs_t;

  obs_t exp_q[$];
  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic         m_run, m_mode, m_err, m_cnt_rst, m_ss, m_init;
  logic [W-1:0] m_min, m_max, m_smin, m_smax;
  int           m_phase, m_age;
  logic [2:0]   m_level;
  logic [DB+1:0] m_hist [3];

  // A level is accepted once the DB samples taken 2..DB+1 edges ago all disagree with it.
  task automatic model_step();
    logic [2:0]    raw, prs;
    logic [DB-1:0] win;
    logic          cur_eff, new_eff, n_cnt_rst;
    obs_t          e;
    if (!rst) begin
      m_run = 1'b0; m_mode = 1'b1; m_err = 1'b0; m_cnt_rst = 1'b1; m_ss = 1'b0; m_init = 1'b1;
      m_min = '0; m_max = '1; m_smin = '0; m_smax = '0;
      m_phase = PH_IDLE; m_age = 0; m_level = 3'b000;
      for (int i = 0; i < 3; i++) m_hist[i] = '0;
    end else begin
      raw = {b_load, b_mode, b_ss};
      for (int i = 0; i < 3; i++) begin
        m_hist[i] = {m_hist[i][DB:0], raw[i]};
        win = m_hist[i][DB+1:2];
        prs[i] = 1'b0;
        if (win == {DB{~m_level[i]}}) begin
          m_level[i] = ~m_level[i];
          prs[i] = m_level[i];
        end
      end
      cur_eff = m_run && (m_phase == PH_IDLE);
      n_cnt_rst = m_init;
      m_init = 1'b0;
      case (m_phase)
        PH_IDLE: begin
          if (prs[2]) m_phase = PH_MIN;
          else if (prs[1]) begin m_mode = ~m_mode; n_cnt_rst = 1'b1; end
          else if (prs[0]) m_run = ~m_run;
        end
        PH_MIN: if (prs[2]) begin m_smin = sw; m_phase = PH_MAX; end
        PH_MAX: if (prs[2]) begin m_smax = sw; m_phase = PH_CHK; end
        default: begin
          m_phase = PH_IDLE;
          if (m_smin <= m_smax) begin
            m_min = m_smin; m_max = m_smax; m_err = 1'b0; n_cnt_rst = 1'b1;
          end else begin
            m_err = 1'b1;
          end
        end
      endcase
      if (cur_eff) m_age++;
      else m_age = 0;
      new_eff = m_run && (m_phase == PH_IDLE);
      m_ss = cur_eff && new_eff && (m_age % TD == 0) && !n_cnt_rst;
      m_cnt_rst = n_cnt_rst;
    end
    e.run = m_run; e.ss = m_ss; e.mode = m_mode; e.mn = m_min; e.mx = m_max;
    e.cnt_rst = m_cnt_rst; e.loading = (m_phase != PH_IDLE); e.err = m_err;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: one expected output set per cycle, sampled on the falling edge.
  initial forever begin
    obs_t e, a;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.run = RUN; a.ss = SS; a.mode = MODE; a.mn = MIN; a.mx = MAX;
      a.cnt_rst = CNT_RST; a.loading = LOADING; a.err = ERR;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got run=%b ss=%b mode=%b min=%0d max=%0d cnt_rst=%b loading=%b err=%b; want run=%b ss=%b mode=%b min=%0d max=%0d cnt_rst=%b loading=%b err=%b",
                 $time, a.run, a.ss, a.mode, a.mn, a.mx, a.cnt_rst, a.loading, a.err,
                 e.run, e.ss, e.mode, e.mn, e.mx, e.cnt_rst, e.loading, e.err);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [2:0] v);
    {b_load, b_mode, b_ss} = v;
  endtask

  task automatic push(input logic [2:0] v, input int hold);
    set_btns(v);
    tick(hold);
    set_btns(3'b000);
    tick(DB + 4);
  endtask

  initial begin
    logic [2:0] v;
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(4);
    // Short glitches, then a long hold that starts running.
    for (int g = 1; g <= 3; g++) push(3'b001, g);
    push(3'b001, 20);
    tick(35);
    push(3'b001, 8);
    tick(12);
    push(3'b001, 8);
    tick(30);
    // Good load, bad load, equal limits.
    push(3'b100, 8); sw = 4'd3; push(3'b100, 8); sw = 4'd12; push(3'b100, 8); tick(5);
    push(3'b100, 8); sw = 4'd9; push(3'b100, 8); sw = 4'd2; push(3'b100, 8); tick(5);
    push(3'b100, 8); sw = 4'd5; push(3'b100, 8); push(3'b100, 8); tick(5);
    // Collisions and ignored presses during entry.
    push(3'b011, 10); tick(5);
    push(3'b100, 8); push(3'b001, 8); sw = 4'd1; push(3'b100, 8); sw = 4'd7; push(3'b100, 8); tick(5);
    push(3'b110, 8); push(3'b100, 8); push(3'b100, 8); tick(5);
    // Reset mid-run and mid-GET_MAX.
    push(3'b001, 8); tick(13);
    rst = 1'b0; tick(3); rst = 1'b1; tick(3);
    push(3'b001, 8); tick(17);
    rst = 1'b0; tick(2); rst = 1'b1; tick(4);
    push(3'b100, 8); push(3'b100, 8);
    rst = 1'b0; tick(2); rst = 1'b1; tick(6);
    // Random traffic with occasional bounce, overlap and reset.
    repeat (200) begin
      v = 3'b001 << $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) v = v | (3'b001 << $urandom_range(0, 2));
      sw = W'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(2, 8)) begin
          set_btns(v & {3{1'($urandom_range(0, 1))}});
          tick(1 + $urandom_range(0, 3));
        end
      end
      set_btns(v);
      tick($urandom_range(1, 12));
      set_btns(3'b000);
      tick($urandom_range(1, 25));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b0; tick(2); rst = 1'b1;
      end
    end
    tick(10);
    if (checks < 100) begin
      errors++;
      $display("FAIL check_count: got %0d comparisons, want at least 100", checks);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
